// File: rtl/cla_addsub_pipe.sv
// -----------------------------------------------------------------------------
// cla_addsub_pipe
//   Pipelined carry-lookahead adder/subtractor. WIDTH-bit operands are cut into
//   STAGES slices of SW = WIDTH/STAGES bits. Stage k adds slice k with a ripple
//   of 4-bit CLA groups, and the carry is registered between stages. Each stage
//   register holds the finished low result slices, the still-unprocessed upper
//   operand slices (skew) and the slice carry-out. The last stage register is
//   the output register. A valid/ready chain gives full backpressure, so the
//   pipeline holds up to STAGES beats.
//
//   Optional feature macro: ADDSUB_FLAGS_EN
//     defined   : ovf/zero/neg are computed in the last stage and registered
//                 together with S.
//     undefined : ovf/zero/neg are tied low and their registers are not built.
//
// Ports
//   clk        rising-edge clock
//   clr_n      synchronous active-low reset (clears all valid bits and outputs)
//   in_valid   operand beat present
//   in_ready   stage 0 can take a beat this cycle
//   A, B       operands (WIDTH)
//   sub        0: A+B+cin   1: A+~B+1 (cin ignored)
//   cin        carry-in for add
//   out_valid  result beat present
//   out_ready  consumer takes the result this cycle
//   S          sum/difference (WIDTH)
//   cout       carry out of MSB (subtract: 1 = no borrow)
//   ovf        signed overflow
//   zero       S == 0
//   neg        S[WIDTH-1]
//
// Parameters
//   WIDTH   operand width, multiple of 4*STAGES
//   STAGES  1, 2, 4 or 8
// -----------------------------------------------------------------------------

// 4-bit carry-lookahead group: all internal carries from generate/propagate.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] p, g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[3:0];
  assign co = c[4];
endmodule

// One pipeline slice: SW/4 CLA groups with the group carry rippled through.
module cla_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co
);
  localparam int NG = SW / 4;

  logic [NG:0] gc;

  assign gc[0] = ci;

  genvar gi;
  for (gi = 0; gi < NG; gi++) begin : grp
    cla4 u_cla4 (
      .a  (a[4*gi +: 4]),
      .b  (b[4*gi +: 4]),
      .ci (gc[gi]),
      .s  (s[4*gi +: 4]),
      .co (gc[gi+1])
    );
  end

  assign co = gc[NG];
endmodule

module cla_addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);
  localparam int SW = WIDTH / STAGES;

  // Subtraction folds into addition: invert B and force the carry-in to 1.
  logic [WIDTH-1:0] bx;
  logic             ceff;

  assign bx   = B ^ {WIDTH{sub}};
  assign ceff = sub | cin;

  // vld_pipe[0] is the incoming beat; vld_pipe[k+1] is stage k's register.
  // adv[k+1] means stage k's register may load this cycle; adv[STAGES+1] is
  // the consumer. The advance chain runs back from out_ready, so in_ready
  // never looks at in_valid.
  logic [STAGES:0]   vld_pipe;
  logic [STAGES+1:1] adv;

  assign vld_pipe[0]    = in_valid;
  assign adv[STAGES+1]  = out_ready;
  assign in_ready       = adv[1];
  assign out_valid      = vld_pipe[STAGES];

  genvar k;
  for (k = 0; k < STAGES; k++) begin : gs
    logic [SW-1:0]         a_s, b_s, s_s;
    logic                  c_s, co_s;
    logic [(k+1)*SW-1:0]   lo_d, lo_q;
    logic                  c_q, v_q, ld;

    assign adv[k+1]      = !v_q || adv[k+2];
    assign ld            = adv[k+1] && vld_pipe[k];
    assign vld_pipe[k+1] = v_q;

    // Slice operands: stage 0 reads the ports, later stages read the lowest
    // skewed slice left by the previous stage.
    if (k == 0) begin : g_src
      assign a_s  = A[SW-1:0];
      assign b_s  = bx[SW-1:0];
      assign c_s  = ceff;
      assign lo_d = s_s;
    end else begin : g_src
      assign a_s  = gs[k-1].g_ops.a_q[SW-1:0];
      assign b_s  = gs[k-1].g_ops.b_q[SW-1:0];
      assign c_s  = gs[k-1].c_q;
      assign lo_d = {s_s, gs[k-1].lo_q};
    end

    cla_slice #(.SW(SW)) u_slice (
      .a  (a_s),
      .b  (b_s),
      .ci (c_s),
      .s  (s_s),
      .co (co_s)
    );

    always_ff @(posedge clk) begin
      if (!clr_n) begin
        v_q  <= 1'b0;
        lo_q <= '0;
        c_q  <= 1'b0;
      end else begin
        if (adv[k+1]) v_q <= vld_pipe[k];
        if (ld) begin
          lo_q <= lo_d;
          c_q  <= co_s;
        end
      end
    end

    // Skew registers: upper operand slices still waiting for their stage.
    // The last stage has none left.
    if (k < STAGES-1) begin : g_ops
      localparam int UW = WIDTH - (k+1)*SW;
      logic [UW-1:0] a_d, b_d, a_q, b_q;

      if (k == 0) begin : g_skw
        assign a_d = A[WIDTH-1:SW];
        assign b_d = bx[WIDTH-1:SW];
      end else begin : g_skw
        assign a_d = gs[k-1].g_ops.a_q[UW+SW-1:SW];
        assign b_d = gs[k-1].g_ops.b_q[UW+SW-1:SW];
      end

      always_ff @(posedge clk) begin
        if (!clr_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ld) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == STAGES-1) begin : g_out
      assign S    = lo_q;
      assign cout = c_q;
`ifdef ADDSUB_FLAGS_EN
      // Carry into the MSB is recovered from the MSB sum bit; overflow is
      // that carry disagreeing with the carry out of the MSB.
      logic c_msb, ovf_q, zero_q, neg_q;

      assign c_msb = s_s[SW-1] ^ a_s[SW-1] ^ b_s[SW-1];

      always_ff @(posedge clk) begin
        if (!clr_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
          neg_q  <= 1'b0;
        end else if (ld) begin
          ovf_q  <= c_msb ^ co_s;
          zero_q <= (lo_d == '0);
          neg_q  <= lo_d[WIDTH-1];
        end
      end

      assign ovf  = ovf_q;
      assign zero = zero_q;
      assign neg  = neg_q;
`else
      assign ovf  = 1'b0;
      assign zero = 1'b0;
      assign neg  = 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: WIDTH=32/STAGES=4 main instance with directed
// vectors, backpressure and mid-stream reset; three WIDTH=16 instances
// (STAGES=1,2,4) for the latency / result sweep.
module tb_cla_addsub_pipe;
`ifdef ADDSUB_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // ---------------- main 32-bit instance ----------------
  logic        clr_n, in_valid, in_ready, sub, cin, out_valid, out_ready;
  logic [31:0] A, B, S;
  logic        cout, ovf, zero, neg;

  cla_addsub_pipe #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sub(sub), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .S(S), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  // ---------------- 16-bit sweep instances ----------------
  logic        in_valid16, sub16;
  logic [15:0] A16, B16;
  logic [2:0]  ir16, ov16, co16, of16, zf16, nf16;
  logic [15:0] s16 [3];

  cla_addsub_pipe #(.WIDTH(16), .STAGES(1)) u_w1 (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid16), .in_ready(ir16[0]),
    .A(A16), .B(B16), .sub(sub16), .cin(1'b0), .out_valid(ov16[0]),
    .out_ready(1'b1), .S(s16[0]), .cout(co16[0]), .ovf(of16[0]), .zero(zf16[0]), .neg(nf16[0])
  );
  cla_addsub_pipe #(.WIDTH(16), .STAGES(2)) u_w2 (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid16), .in_ready(ir16[1]),
    .A(A16), .B(B16), .sub(sub16), .cin(1'b0), .out_valid(ov16[1]),
    .out_ready(1'b1), .S(s16[1]), .cout(co16[1]), .ovf(of16[1]), .zero(zf16[1]), .neg(nf16[1])
  );
  cla_addsub_pipe #(.WIDTH(16), .STAGES(4)) u_w4 (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid16), .in_ready(ir16[2]),
    .A(A16), .B(B16), .sub(sub16), .cin(1'b0), .out_valid(ov16[2]),
    .out_ready(1'b1), .S(s16[2]), .cout(co16[2]), .ovf(of16[2]), .zero(zf16[2]), .neg(nf16[2])
  );

  // One beat through the 32-bit instance, checked against hand values.
  task automatic op(input string tg, input logic [31:0] a, input logic [31:0] b,
                    input logic sb, input logic ci, input logic [31:0] es,
                    input logic ec, input logic eo, input logic ez, input logic en);
    int lat;
    @(negedge clk);
    A = a; B = b; sub = sb; cin = ci; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tg, ".rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tg, ".lat"}, lat, 4);
    chk({tg, ".S"}, S, es);
    chk({tg, ".cout"}, cout, ec);
    chk({tg, ".flags"}, {ovf, zero, neg}, {eo & FL, ez & FL, en & FL});
  endtask

  // One beat through all three 16-bit instances; reference is plain arithmetic.
  task automatic sweep_op(input int n, input logic [15:0] a, input logic [15:0] b, input logic sb);
    int          lat [3];
    logic [15:0] got [3];
    logic [3:0]  gfl [3];
    logic [16:0] full;
    logic [15:0] bxe;
    logic        eo;
    int          exl [3];
    exl = '{1, 2, 4};
    lat = '{0, 0, 0};
    bxe  = sb ? ~b : b;
    full = {1'b0, a} + {1'b0, bxe} + {16'd0, sb};
    eo   = (a[15] == bxe[15]) && (full[15] != a[15]);
    @(negedge clk);
    A16 = a; B16 = b; sub16 = sb; in_valid16 = 1'b1;
    @(negedge clk);
    in_valid16 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      for (int j = 0; j < 3; j++)
        if (ov16[j] && lat[j] == 0) begin
          lat[j] = c;
          got[j] = s16[j];
          gfl[j] = {co16[j], of16[j], zf16[j], nf16[j]};
        end
      @(negedge clk);
    end
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("sw%0d.st%0d.lat", n, exl[j]), lat[j], exl[j]);
      chk($sformatf("sw%0d.st%0d.S", n, exl[j]), got[j], full[15:0]);
      chk($sformatf("sw%0d.st%0d.cf", n, exl[j]), gfl[j],
          {full[16], eo & FL, (full[15:0] == 16'd0) & FL, full[15] & FL});
    end
  endtask

  initial begin
    clr_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; sub = 1'b0; cin = 1'b0;
    in_valid16 = 1'b0; A16 = '0; B16 = '0; sub16 = 1'b0;

    // Reset held for two edges
    @(negedge clk);
    @(negedge clk);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.S", S, 0);
    chk("rst.cf", {cout, ovf, zero, neg}, 0);
    clr_n = 1'b1;

    // Directed vectors
    op("add5p3",   32'h0000_0005, 32'h0000_0003, 0, 0, 32'h0000_0008, 0, 0, 0, 0);
    op("wrap",     32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 32'h0000_0000, 1, 0, 1, 0);
    op("subovf",   32'h8000_0000, 32'h0000_0001, 1, 0, 32'h7FFF_FFFF, 1, 1, 0, 0);
    op("sub3m5",   32'h0000_0003, 32'h0000_0005, 1, 0, 32'hFFFF_FFFE, 0, 0, 0, 1);
    op("cinxst",   32'h0000_FFFF, 32'h0000_0000, 0, 1, 32'h0001_0000, 0, 0, 0, 0);
    op("addovf",   32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 1, 0, 1);
    op("subzero",  32'h0000_0007, 32'h0000_0007, 1, 0, 32'h0000_0000, 1, 0, 1, 0);
    op("addcin",   32'h1234_5678, 32'h1111_1111, 0, 1, 32'h2345_678A, 0, 0, 0, 0);

    // Stream 10 beats with out_ready low for cycles 3..8
    begin : bp
      logic [31:0] q[$];
      logic [31:0] prev;
      int   sent, hold_seen, extra;
      bit   stalled;
      sent = 0; hold_seen = 0; stalled = 0; prev = '0; extra = 0;
      for (int cyc = 0; cyc < 60 && q.size() < 10; cyc++) begin
        @(negedge clk);
        out_ready = !(cyc >= 3 && cyc <= 8);
        in_valid  = (sent < 10);
        A = sent + 1; B = sent + 1; sub = 1'b0; cin = 1'b0;
        #1;
        if (!in_ready && hold_seen == 0) begin
          hold_seen = 1;
          chk("bp.held", sent - q.size(), 4);
        end
        if (out_valid && !out_ready) begin
          if (stalled) chk("bp.stable", S, prev);
          prev = S;
          stalled = 1'b1;
        end else stalled = 1'b0;
        if (out_valid && out_ready) q.push_back(S);
        if (in_valid && in_ready) sent++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (out_valid) extra++;
      end
      chk("bp.hold_seen", hold_seen, 1);
      chk("bp.count", q.size(), 10);
      chk("bp.extra", extra, 0);
      for (int i = 0; i < 10 && i < q.size(); i++)
        chk($sformatf("bp.S%0d", i), q[i], 2 * (i + 1));
    end

    // Reset with 3 beats in flight, and an accept attempt in the reset cycle
    begin : rs
      int seen;
      seen = 0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        A = 100 + i; B = 1; in_valid = 1'b1;
      end
      @(negedge clk);
      clr_n = 1'b0; A = 32'h55; in_valid = 1'b1;
      @(negedge clk);
      chk("rs.out_valid", out_valid, 0);
      chk("rs.in_ready", in_ready, 1);
      clr_n = 1'b1; in_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("rs.stale", seen, 0);
    end

    // 16-bit sweep
    sweep_op(0, 16'hFFFF, 16'h0001, 1'b0);
    sweep_op(1, 16'h1234, 16'h4321, 1'b1);
    for (int n = 2; n < 6; n++)
      sweep_op(n, 16'($urandom), 16'($urandom), 1'(n & 1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
